// File: rtl/cmp_result_monitor.sv
// ----------------------------------------------------------------------------
// cmp_result_monitor
//
// Watches the G/L/E flags of an upstream magnitude comparator. It counts the
// accepted results of each class, tracks runs of identical consecutive
// results, and flags malformed samples (none or more than one flag set).
//
// Parameters
//   CNT_W    width of each saturating result counter
//   RUN_LEN  run length (2..15) that raises run_hit
//
// Ports
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset (deassertion synchronised)
//   in_valid    G/L/E carry a sample this cycle
//   G, L, E     comparator flags A>B, A<B, A==B
//   clr         synchronous clear; wins over a simultaneous sample
//   gt_cnt      accepted G results (saturating)
//   lt_cnt      accepted L results (saturating)
//   eq_cnt      accepted E results (saturating)
//   run_state   current run class: 00 none, 01 GT, 10 LT, 11 EQ
//   run_hit     one-cycle pulse when the run length first reaches RUN_LEN
//   flag_err    one-cycle pulse on a malformed sample
//   err_sticky  set by any malformed sample, held until clr or reset
// ----------------------------------------------------------------------------
module cmp_result_monitor #(
    parameter int CNT_W   = 8,
    parameter int RUN_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             G,
    input  logic             L,
    input  logic             E,
    input  logic             clr,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [1:0]       run_state,
    output logic             run_hit,
    output logic             flag_err,
    output logic             err_sticky
);

    // The encoding doubles as the run_state output code.
    typedef enum logic [1:0] {
        ST_NONE = 2'b00,
        ST_GT   = 2'b01,
        ST_LT   = 2'b10,
        ST_EQ   = 2'b11
    } runState_e;

    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [3:0]       RUN_MAX    = 4'd15;
    localparam logic [3:0]       RUN_TARGET = 4'(RUN_LEN);

    // ------------------------------------------------------------------------
    // Reset synchroniser: the internal reset asserts as soon as rst_n falls
    // and is released two clock edges after rst_n rises, so the first edge
    // the state registers see after reset is clean.
    // ------------------------------------------------------------------------
    logic [1:0] rstSync_q;
    logic       rstIntN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstSync_q <= 2'b00;
        end else begin
            rstSync_q <= {rstSync_q[0], 1'b1};
        end
    end

    assign rstIntN = rstSync_q[1];

    // ------------------------------------------------------------------------
    // Sample decode. A sample is well formed only when exactly one flag is
    // set; every other pattern decodes to ST_NONE and is treated as
    // malformed whenever in_valid is high.
    // ------------------------------------------------------------------------
    runState_e sampleClass;
    logic      sampleOk;
    logic      sampleBad;

    always_comb begin
        sampleClass = ST_NONE;
        unique case ({G, L, E})
            3'b100:  sampleClass = ST_GT;
            3'b010:  sampleClass = ST_LT;
            3'b001:  sampleClass = ST_EQ;
            default: sampleClass = ST_NONE;
        endcase
    end

    assign sampleOk  = in_valid && (sampleClass != ST_NONE);
    assign sampleBad = in_valid && (sampleClass == ST_NONE);

    // ------------------------------------------------------------------------
    // State registers and their next values.
    // ------------------------------------------------------------------------
    runState_e        state_q,     state_d;
    logic [3:0]       runLen_q,    runLen_d;
    logic [CNT_W-1:0] gtCnt_q,     gtCnt_d;
    logic [CNT_W-1:0] ltCnt_q,     ltCnt_d;
    logic [CNT_W-1:0] eqCnt_q,     eqCnt_d;
    logic             runHit_q,    runHit_d;
    logic             flagErr_q,   flagErr_d;
    logic             errSticky_q, errSticky_d;

    // Run length after one more matching sample, held at 15 once there.
    logic [3:0] runLenInc;
    assign runLenInc = (runLen_q == RUN_MAX) ? RUN_MAX : runLen_q + 4'd1;

    // ------------------------------------------------------------------------
    // Next-state logic. Priority is clr, then a valid sample (good or bad);
    // with no valid sample everything holds and both pulses drop.
    // run_hit fires only on the step where the length moves onto RUN_LEN,
    // so a run that keeps going (or sits saturated at 15) never re-fires.
    // A change of class always restarts at length 1, and RUN_LEN >= 2, so
    // a class change can never produce a hit.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        runLen_d    = runLen_q;
        gtCnt_d     = gtCnt_q;
        ltCnt_d     = ltCnt_q;
        eqCnt_d     = eqCnt_q;
        runHit_d    = 1'b0;
        flagErr_d   = 1'b0;
        errSticky_d = errSticky_q;

        if (clr) begin
            state_d     = ST_NONE;
            runLen_d    = 4'd0;
            gtCnt_d     = '0;
            ltCnt_d     = '0;
            eqCnt_d     = '0;
            errSticky_d = 1'b0;
        end else if (sampleBad) begin
            state_d     = ST_NONE;
            runLen_d    = 4'd0;
            flagErr_d   = 1'b1;
            errSticky_d = 1'b1;
        end else if (sampleOk) begin
            unique case (sampleClass)
                ST_GT: if (gtCnt_q != CNT_MAX) gtCnt_d = gtCnt_q + CNT_W'(1);
                ST_LT: if (ltCnt_q != CNT_MAX) ltCnt_d = ltCnt_q + CNT_W'(1);
                ST_EQ: if (eqCnt_q != CNT_MAX) eqCnt_d = eqCnt_q + CNT_W'(1);
                default: ;
            endcase

            if (sampleClass == state_q) begin
                runLen_d = runLenInc;
                runHit_d = (runLenInc == RUN_TARGET) && (runLen_q != RUN_TARGET);
            end else begin
                state_d  = sampleClass;
                runLen_d = 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM and output registers, all reset by the synchronised reset. Because
    // the synchroniser flops clear asynchronously, pulling rst_n low clears
    // these registers immediately without waiting for a clock edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstIntN) begin
        if (!rstIntN) begin
            state_q     <= ST_NONE;
            runLen_q    <= 4'd0;
            gtCnt_q     <= '0;
            ltCnt_q     <= '0;
            eqCnt_q     <= '0;
            runHit_q    <= 1'b0;
            flagErr_q   <= 1'b0;
            errSticky_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            runLen_q    <= runLen_d;
            gtCnt_q     <= gtCnt_d;
            ltCnt_q     <= ltCnt_d;
            eqCnt_q     <= eqCnt_d;
            runHit_q    <= runHit_d;
            flagErr_q   <= flagErr_d;
            errSticky_q <= errSticky_d;
        end
    end

    assign gt_cnt     = gtCnt_q;
    assign lt_cnt     = ltCnt_q;
    assign eq_cnt     = eqCnt_q;
    assign run_state  = state_q;
    assign run_hit    = runHit_q;
    assign flag_err   = flagErr_q;
    assign err_sticky = errSticky_q;

endmodule

// File: tb/tb_cmp_result_monitor.sv
// ----------------------------------------------------------------------------
// tb_cmp_result_monitor
//
// Drives cmp_result_monitor with directed scenarios followed by biased random
// traffic, and compares every output after every edge against a behavioural
// model that tracks counts and the current run as plain integers.
// ----------------------------------------------------------------------------
module tb_cmp_result_monitor;

    localparam int CNT_W   = 4;
    localparam int RUN_LEN = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int LEN_MAX = 15;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             G;
    logic             L;
    logic             E;
    logic             clr;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [1:0]       run_state;
    logic             run_hit;
    logic             flag_err;
    logic             err_sticky;

    cmp_result_monitor #(
        .CNT_W   (CNT_W),
        .RUN_LEN (RUN_LEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .G          (G),
        .L          (L),
        .E          (E),
        .clr        (clr),
        .gt_cnt     (gt_cnt),
        .lt_cnt     (lt_cnt),
        .eq_cnt     (eq_cnt),
        .run_state  (run_state),
        .run_hit    (run_hit),
        .flag_err   (flag_err),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: counts per class, the class of the current run
    // (0 none, 1 GT, 2 LT, 3 EQ) and its length, plus the expected pulses.
    int mGt, mLt, mEq, mClass, mLen;
    int mHit, mErr, mSticky;

    // Compares one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mGt = 0; mLt = 0; mEq = 0; mClass = 0; mLen = 0;
        mHit = 0; mErr = 0; mSticky = 0;
    endtask

    // Applies the rules for one clock edge with the given inputs.
    task automatic modelStep(input bit v, input bit g, input bit l, input bit e,
                             input bit c);
        int hot;
        int cls;
        int prevLen;
        mHit = 0;
        mErr = 0;
        hot  = int'(g) + int'(l) + int'(e);
        if (c) begin
            mGt = 0; mLt = 0; mEq = 0; mClass = 0; mLen = 0; mSticky = 0;
        end else if (v && hot != 1) begin
            mErr = 1; mSticky = 1; mClass = 0; mLen = 0;
        end else if (v) begin
            cls = g ? 1 : (l ? 2 : 3);
            if (cls == 1) mGt = (mGt < CNT_MAX) ? mGt + 1 : CNT_MAX;
            if (cls == 2) mLt = (mLt < CNT_MAX) ? mLt + 1 : CNT_MAX;
            if (cls == 3) mEq = (mEq < CNT_MAX) ? mEq + 1 : CNT_MAX;
            prevLen = (cls == mClass) ? mLen : 0;
            mClass  = cls;
            mLen    = (prevLen + 1 > LEN_MAX) ? LEN_MAX : prevLen + 1;
            mHit    = (mLen == RUN_LEN && prevLen < RUN_LEN) ? 1 : 0;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".gt_cnt"},     32'(gt_cnt),     32'(mGt));
        checkOutput({tag, ".lt_cnt"},     32'(lt_cnt),     32'(mLt));
        checkOutput({tag, ".eq_cnt"},     32'(eq_cnt),     32'(mEq));
        checkOutput({tag, ".run_state"},  32'(run_state),  32'(mClass));
        checkOutput({tag, ".run_hit"},    32'(run_hit),    32'(mHit));
        checkOutput({tag, ".flag_err"},   32'(flag_err),   32'(mErr));
        checkOutput({tag, ".err_sticky"}, 32'(err_sticky), 32'(mSticky));
    endtask

    // Drives one cycle of inputs, advances the model across the edge and
    // checks every output 1 time unit after the edge.
    task automatic applyStimulus(input string tag, input bit v, input bit g,
                                 input bit l, input bit e, input bit c);
        in_valid = v; G = g; L = l; E = e; clr = c;
        @(posedge clk);
        modelStep(v, g, l, e, c);
        #1;
        checkAll(tag);
    endtask

    task automatic idleCycles(input string tag, input int n);
        for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clearAll();
        applyStimulus("clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    int hits;
    int lastCls;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; G = 1'b0; L = 1'b0; E = 1'b0; clr = 1'b0;
        modelReset();

        // Reset state, checked while reset is held across several edges.
        #22;
        checkAll("reset");
        #1 rst_n = 1'b1;
        idleCycles("release", 3);

        // Run detection on E.
        for (int i = 0; i < 4; i++) applyStimulus("run_eq", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("run_eq.hit4", 32'(run_hit), 32'd1);
        checkOutput("run_eq.cnt4", 32'(eq_cnt), 32'd4);
        applyStimulus("run_eq5", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("run_eq.hit5", 32'(run_hit), 32'd0);
        checkOutput("run_eq.cnt5", 32'(eq_cnt), 32'd5);
        clearAll();

        // Run broken by a single L: G,G,G,L,G,G,G,G.
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) applyStimulus("break", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            else        applyStimulus("break", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            hits += int'(run_hit);
        end
        checkOutput("break.hits", 32'(hits), 32'd1);
        checkOutput("break.gt", 32'(gt_cnt), 32'd7);
        checkOutput("break.state", 32'(run_state), 32'd1);
        clearAll();

        // Malformed samples: multi-hot then all-zero.
        applyStimulus("bad_multi", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("bad_multi.flag", 32'(flag_err), 32'd1);
        applyStimulus("bad_zero", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("bad_zero.flag", 32'(flag_err), 32'd1);
        idleCycles("bad_hold", 2);
        checkOutput("bad_hold.sticky", 32'(err_sticky), 32'd1);
        clearAll();
        checkOutput("bad_clr.sticky", 32'(err_sticky), 32'd0);

        // Counter saturation with 20 L samples.
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus("sat_lt", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            hits += int'(run_hit);
        end
        checkOutput("sat_lt.cnt", 32'(lt_cnt), 32'd15);
        checkOutput("sat_lt.hits", 32'(hits), 32'd1);
        clearAll();

        // Gaps do not break a run; clr discards a simultaneous sample.
        applyStimulus("gap", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idleCycles("gap_idle", 3);
        for (int i = 0; i < 3; i++) applyStimulus("gap", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("gap.hit", 32'(run_hit), 32'd1);
        applyStimulus("clr_eq", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("clr_eq.eq", 32'(eq_cnt), 32'd0);
        checkOutput("clr_eq.state", 32'(run_state), 32'd0);

        // Asynchronous reset between edges in the middle of a run.
        applyStimulus("async_pre", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("async_pre", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("async_low");
        #1 rst_n = 1'b1;
        idleCycles("async_rel", 3);
        applyStimulus("async_post", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("async_post.eq", 32'(eq_cnt), 32'd1);
        checkOutput("async_post.state", 32'(run_state), 32'd3);

        // Biased random traffic: mostly repeated classes to build runs, with
        // occasional gaps, malformed patterns and clears.
        lastCls = 1;
        for (int i = 0; i < 600; i++) begin
            bit v, g, l, e, c;
            int cls;
            int pat;
            c = ($urandom_range(0, 99) < 3);
            v = ($urandom_range(0, 99) < 80);
            g = 1'b0; l = 1'b0; e = 1'b0;
            if ($urandom_range(0, 99) < 8) begin
                pat = $urandom_range(0, 4);
                case (pat)
                    0: begin g = 1'b0; l = 1'b0; e = 1'b0; end
                    1: begin g = 1'b1; l = 1'b1; e = 1'b0; end
                    2: begin g = 1'b1; l = 1'b0; e = 1'b1; end
                    3: begin g = 1'b0; l = 1'b1; e = 1'b1; end
                    default: begin g = 1'b1; l = 1'b1; e = 1'b1; end
                endcase
            end else begin
                cls = ($urandom_range(0, 99) < 75) ? lastCls : int'($urandom_range(1, 3));
                lastCls = cls;
                g = (cls == 1); l = (cls == 2); e = (cls == 3);
            end
            applyStimulus("rand", v, g, l, e, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp_result_monitor.md
CMP_RESULT_MONITOR -- requirements
Module: cmp_result_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of each result counter.
REQ-002 Parameter RUN_LEN, default 4, legal 2..15: identical consecutive results that raise run_hit.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  G/L/E sample is valid this cycle.
REQ-006 G  input  1  upstream 4-bit comparator "A>B" flag.
REQ-007 L  input  1  upstream comparator "A<B" flag.
REQ-008 E  input  1  upstream comparator "A==B" flag.
REQ-009 clr  input  1  synchronous clear of counters, run state and sticky error.
REQ-010 gt_cnt  output  CNT_W  count of accepted G results.
REQ-011 lt_cnt  output  CNT_W  count of accepted L results.
REQ-012 eq_cnt  output  CNT_W  count of accepted E results.
REQ-013 run_state  output  2  current run class: 00 none, 01 GT, 10 LT, 11 EQ.
REQ-014 run_hit  output  1  one-cycle pulse when the current run length reaches RUN_LEN.
REQ-015 flag_err  output  1  one-cycle pulse on a malformed sample.
REQ-016 err_sticky  output  1  set by any malformed sample; held until clr or reset.

Function
REQ-017 All outputs SHALL be registered; the effect of a sample at edge N SHALL be visible after edge N.
REQ-018 A sample is accepted when in_valid=1 and exactly one of G, L, E is 1; with in_valid=0 the block SHALL hold all state and drive run_hit=0, flag_err=0.
REQ-019 An accepted sample SHALL increment the matching counter by 1; counters SHALL saturate at 2^CNT_W-1, with no wrap to 0.
REQ-020 The FSM SHALL have states NONE, GT, LT, EQ, with run_state mirroring the state encoding in REQ-013.
REQ-021 FSM transitions on an accepted sample:
- same class as the current state: run length +1, saturating at 15;
- different class, or from NONE: move to that class, run length = 1.
REQ-022 run_hit SHALL pulse for exactly one cycle on the sample that makes the run length equal RUN_LEN, and SHALL NOT pulse again until the run is broken.
REQ-023 Malformed sample (in_valid=1 and G+L+E != 1, including all-zero and multi-hot):
- flag_err=1 for one cycle and err_sticky=1;
- no counter changes;
- FSM -> NONE and run length -> 0;
- run_hit=0.
REQ-024 clr=1 SHALL, at the next edge, zero all counters and run length, force NONE, and clear err_sticky and both pulse outputs; clr SHALL take priority over a simultaneous sample, which is discarded.
REQ-025 run_hit and flag_err SHALL never assert in the same cycle.

Reset
REQ-026 While rst_n=0, regardless of clk:
- gt_cnt, lt_cnt, eq_cnt = 0;
- run_state = 00, run length = 0;
- run_hit, flag_err, err_sticky = 0.
REQ-027 Reset asserted mid-run SHALL discard the run in progress; after release the first accepted sample SHALL start a run of length 1.
REQ-028 rst_n deassertion SHALL be synchronised to clk internally so the first active edge is clean.

Verification
REQ-029 Run detection: after reset, 4 consecutive valid E=1 samples with RUN_LEN=4 -> eq_cnt=4, run_state=11, run_hit pulses only after the 4th edge; a 5th E sample -> eq_cnt=5, no run_hit.
REQ-030 Run break: samples G,G,G,L,G,G,G,G -> gt_cnt=7, lt_cnt=1, run_hit exactly once (after the 8th sample), final run_state=01.
REQ-031 Malformed input: valid G=1,E=1 then G=0,L=0,E=0 -> two flag_err pulses, counters unchanged, run_state=00, err_sticky=1 until a clr pulse clears it.
REQ-032 Saturation: with CNT_W=4, 20 valid L samples -> lt_cnt=15 and holds; run_hit once after the 4th sample.
REQ-033 Gaps and clear: G, in_valid=0 for 3 cycles, G,G,G -> run_hit after the 4th G; clr asserted together with a valid E -> all counters 0, run_state=00, E discarded.
REQ-034 Async reset: rst_n pulled low between edges mid-run -> all outputs 0 immediately, without waiting for clk; after release, one E sample -> eq_cnt=1, run_state=11.
